// File: rtl/maria_reg_bank.sv
// MARIA register bank: colours, CTRL, CHARBASE, double-buffered DPP and WSYNC CPU hold.
// Writes land on the strobe edge; reads return one cycle later; the CPU is stalled via cpu_ready, never the bus.
module maria_reg_bank #(
  parameter int          NUM_PAL  = 8,
  parameter int          AW       = $clog2(4*NUM_PAL),
  parameter logic [7:0]  OPEN_BUS = 8'hBE,
  parameter logic [15:0] ZP_RESET = 16'h1820
) (
  input  logic                          sysclock,
  input  logic                          reset_b,
  input  logic                          bus_stb,
  input  logic                          sel,
  input  logic [AW-1:0]                 addr,
  input  logic                          we_b,
  input  logic [7:0]                    wdata,
  output logic [7:0]                    rdata,
  output logic                          rvalid,
  input  logic [7:0]                    status,
  input  logic                          hblank_pulse,
  input  logic                          frame_start,
  output logic                          cpu_ready,
  output logic [(3*NUM_PAL+1)*8-1:0]    color_map,
  output logic [7:0]                    ctrl,
  output logic [7:0]                    char_base,
  output logic [15:0]                   zp,
  output logic                          zp_valid
);

  localparam int NC = 3*NUM_PAL + 1;
  localparam int IW = $clog2(NC);

  typedef enum logic {RUN, HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  colors [NC];
  logic [15:0] shadow;
  logic        pend_h, pend_l;
  logic        acc, wr, rd, lane0;
  logic [AW-3:0] grp;
  logic [1:0]  lane;
  logic [31:0] gi;
  logic [IW-1:0] cidx;
  logic        col_wr, wsync_wr, dpph_wr, dppl_wr, cb_wr, ctrl_wr;
  logic [7:0]  rd_mux;

  assign acc   = bus_stb & sel;
  assign wr    = acc & ~we_b;
  assign rd    = acc & we_b;
  assign grp   = addr[AW-1:2];
  assign lane  = addr[1:0];
  assign lane0 = (lane == 2'd0);
  assign gi    = 32'(grp);
  // Slot 0 (g=0, l=0) maps to index 0 as well, which is BKGRND.
  assign cidx  = IW'(gi*3 + 32'(lane));

  assign col_wr   = wr & (!lane0 || gi == 0);
  assign wsync_wr = wr & lane0 & (gi == 1);
  assign dpph_wr  = wr & lane0 & (gi == 3);
  assign dppl_wr  = wr & lane0 & (gi == 4);
  assign cb_wr    = wr & lane0 & (gi == 5);
  assign ctrl_wr  = wr & lane0 & (gi == 7);

  genvar i;
  generate
    for (i = 0; i < NC; i++) begin : g_cmap
      assign color_map[8*i +: 8] = colors[i];
    end
  endgenerate

  always_ff @(posedge sysclock) begin
    if (!reset_b) begin
      for (int k = 0; k < NC; k++) colors[k] <= '0;
    end else if (col_wr) begin
      colors[cidx] <= wdata;
    end
  end

  always_ff @(posedge sysclock) begin
    if (!reset_b) begin
      ctrl      <= 8'h40;
      char_base <= 8'h00;
    end else begin
      if (ctrl_wr) ctrl      <= wdata;
      if (cb_wr)   char_base <= wdata;
    end
  end

  // Commit uses the pre-write shadow; a same-cycle DPP write re-arms its pend after the clear.
  always_ff @(posedge sysclock) begin
    if (!reset_b) begin
      shadow   <= ZP_RESET;
      zp       <= ZP_RESET;
      zp_valid <= 1'b0;
      pend_h   <= 1'b0;
      pend_l   <= 1'b0;
    end else begin
      if (frame_start && pend_h && pend_l) begin
        zp       <= shadow;
        zp_valid <= 1'b1;
        pend_h   <= 1'b0;
        pend_l   <= 1'b0;
      end
      if (dpph_wr) begin
        shadow[15:8] <= wdata;
        pend_h       <= 1'b1;
      end
      if (dppl_wr) begin
        shadow[7:0] <= wdata;
        pend_l      <= 1'b1;
      end
    end
  end

  always_ff @(posedge sysclock) begin
    if (!reset_b) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wsync_wr)          state_nxt = HOLD;
    else if (hblank_pulse) state_nxt = RUN;
  end

  assign cpu_ready = (state == RUN);

  always_comb begin
    rd_mux = 8'h00;
    if (!lane0) begin
      rd_mux = colors[cidx];
    end else begin
      case (gi)
        0:             rd_mux = colors[0];
        2:             rd_mux = status;
        1, 3, 4, 5, 7: rd_mux = OPEN_BUS;
        default:       rd_mux = 8'h00;
      endcase
    end
  end

  always_ff @(posedge sysclock) begin
    if (!reset_b) begin
      rdata  <= 8'h00;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_maria_reg_bank.sv
// Directed and random bench for maria_reg_bank (NUM_PAL=8) against a behavioural register model.
module tb_maria_reg_bank;

  localparam int NP = 8;
  localparam int NC = 3*NP + 1;

  logic          sysclock = 1'b0;
  logic          reset_b = 1'b0;
  logic          bus_stb = 1'b0;
  logic          sel = 1'b0;
  logic [4:0]    addr = '0;
  logic          we_b = 1'b1;
  logic [7:0]    wdata = '0;
  logic [7:0]    rdata;
  logic          rvalid;
  logic [7:0]    status = '0;
  logic          hblank_pulse = 1'b0;
  logic          frame_start = 1'b0;
  logic          cpu_ready;
  logic [NC*8-1:0] color_map;
  logic [7:0]    ctrl, char_base;
  logic [15:0]   zp;
  logic          zp_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_col [NC];
  logic [7:0]  m_ctrl, m_cb, m_rdata;
  logic [15:0] m_shadow, m_zp;
  bit          m_ph, m_pl, m_zpv, m_hold, m_rvalid;

  maria_reg_bank #(.NUM_PAL(NP)) dut (
    .sysclock(sysclock), .reset_b(reset_b), .bus_stb(bus_stb), .sel(sel),
    .addr(addr), .we_b(we_b), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .status(status), .hblank_pulse(hblank_pulse), .frame_start(frame_start),
    .cpu_ready(cpu_ready), .color_map(color_map), .ctrl(ctrl),
    .char_base(char_base), .zp(zp), .zp_valid(zp_valid)
  );

  always #5 sysclock = ~sysclock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input int off, input logic [7:0] st);
    int g, l;
    g = off / 4;
    l = off % 4;
    if (l != 0) return m_col[3*g + l];
    case (g)
      0:             return m_col[0];
      2:             return st;
      1, 3, 4, 5, 7: return 8'hBE;
      default:       return 8'h00;
    endcase
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NC; k++) m_col[k] = 8'h00;
    m_ctrl = 8'h40; m_cb = 8'h00; m_rdata = 8'h00; m_rvalid = 0;
    m_shadow = 16'h1820; m_zp = 16'h1820; m_zpv = 0; m_ph = 0; m_pl = 0; m_hold = 0;
  endtask

  task automatic m_step(input bit rst, stb, sl, input int off, input bit web,
                        input logic [7:0] wd, st, input bit hb, fs);
    int g, l;
    bit acc;
    if (rst) begin
      m_reset();
      return;
    end
    g = off / 4;
    l = off % 4;
    acc = stb && sl;
    m_rvalid = acc && web;
    if (m_rvalid) m_rdata = m_read(off, st);
    if (fs && m_ph && m_pl) begin
      m_zp = m_shadow; m_zpv = 1; m_ph = 0; m_pl = 0;
    end
    if (acc && !web) begin
      if (l != 0) m_col[3*g + l] = wd;
      else case (g)
        0: m_col[0] = wd;
        3: begin m_shadow[15:8] = wd; m_ph = 1; end
        4: begin m_shadow[7:0] = wd; m_pl = 1; end
        5: m_cb = wd;
        7: m_ctrl = wd;
        default: ;
      endcase
    end
    if (acc && !web && l == 0 && g == 1) m_hold = 1;
    else if (hb) m_hold = 0;
  endtask

  task automatic check_all(input string tag);
    logic [NC*8-1:0] exp_cm;
    for (int k = 0; k < NC; k++) exp_cm[8*k +: 8] = m_col[k];
    chk({tag, ".rvalid"},    256'(rvalid),    256'(m_rvalid));
    chk({tag, ".rdata"},     256'(rdata),     256'(m_rdata));
    chk({tag, ".cpu_ready"}, 256'(cpu_ready), 256'(!m_hold));
    chk({tag, ".zp"},        256'(zp),        256'(m_zp));
    chk({tag, ".zp_valid"},  256'(zp_valid),  256'(m_zpv));
    chk({tag, ".ctrl"},      256'(ctrl),      256'(m_ctrl));
    chk({tag, ".char_base"}, 256'(char_base), 256'(m_cb));
    chk({tag, ".color_map"}, 256'(color_map), 256'(exp_cm));
  endtask

  // One clock: drive inputs, let the DUT sample them, advance the model, compare.
  task automatic step(input string tag, input bit rst, stb, sl, input int off, input bit web,
                      input logic [7:0] wd, input bit hb, fs);
    logic [7:0] st;
    st = 8'($urandom);
    reset_b = !rst; bus_stb = stb; sel = sl; addr = 5'(off); we_b = web;
    wdata = wd; status = st; hblank_pulse = hb; frame_start = fs;
    @(posedge sysclock);
    #1;
    m_step(rst, stb, sl, off, web, wd, st, hb, fs);
    reset_b = 1'b1; bus_stb = 1'b0; hblank_pulse = 1'b0; frame_start = 1'b0;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input int off, input logic [7:0] wd);
    step(tag, 0, 1, 1, off, 0, wd, 0, 0);
  endtask

  task automatic rd(input string tag, input int off);
    step(tag, 0, 1, 1, off, 1, 8'h00, 0, 0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 0, 0, 0, 0, 1, 8'h00, 0, 0);
  endtask

  initial begin
    m_reset();
    step("reset", 1, 0, 0, 0, 1, 8'h00, 0, 0);
    step("reset2", 1, 1, 1, 4, 0, 8'hFF, 0, 0);
    chk("reset.ctrl_const", 256'(ctrl), 256'(8'h40));
    chk("reset.zp_const", 256'(zp), 256'(16'h1820));

    for (int a = 0; a < 4*NP; a++) rd("rd_all", a);
    idle("rvalid_drop", 1);

    wr("wr_col16", 'h15, 8'h3A);
    rd("rd_col16", 'h15);
    chk("col16_byte", 256'(color_map[16*8 +: 8]), 256'(8'h3A));
    chk("col16_rdata", 256'(rdata), 256'(8'h3A));
    wr("wr_bk", 0, 8'h11);
    wr("wr_ctrl", 28, 8'h5C);
    wr("wr_cb", 20, 8'hA7);
    wr("wr_mstat", 8, 8'h99);
    wr("wr_g6", 24, 8'h77);
    rd("rd_bk", 0);

    wr("dpph_only", 12, 8'h40);
    step("fs_one_pend", 0, 0, 0, 0, 1, 8'h00, 0, 1);
    wr("dppl", 16, 8'h80);
    step("fs_commit", 0, 0, 0, 0, 1, 8'h00, 0, 1);
    chk("zp_4080", 256'(zp), 256'(16'h4080));
    wr("dpph2", 12, 8'h55);
    wr("dppl2", 16, 8'h66);
    step("dppl_with_fs", 0, 1, 1, 16, 0, 8'h77, 0, 1);
    chk("zp_5566", 256'(zp), 256'(16'h5566));
    step("fs_only_l", 0, 0, 0, 0, 1, 8'h00, 0, 1);
    wr("dpph3", 12, 8'h12);
    step("fs_deferred", 0, 0, 0, 0, 1, 8'h00, 0, 1);
    chk("zp_1277", 256'(zp), 256'(16'h1277));

    wr("wsync", 4, 8'h00);
    idle("hold", 10);
    step("hblank", 0, 0, 0, 0, 1, 8'h00, 1, 0);
    idle("released", 1);
    step("wsync_hb", 0, 1, 1, 4, 0, 8'h00, 1, 0);
    idle("hold2", 3);
    step("wsync_in_hold", 0, 1, 1, 4, 0, 8'h00, 0, 0);
    step("hblank2", 0, 0, 0, 0, 1, 8'h00, 1, 0);

    wr("wsync3", 4, 8'h00);
    wr("dpph_pend", 12, 8'hEE);
    step("reset_hold", 1, 0, 0, 0, 1, 8'h00, 0, 0);
    chk("reset_ready", 256'(cpu_ready), 256'(1'b1));
    wr("dppl_after_rst", 16, 8'h01);
    step("fs_after_rst", 0, 0, 0, 0, 1, 8'h00, 0, 1);

    step("nosel_wr", 0, 1, 0, 28, 0, 8'h01, 0, 0);
    step("nostb_wr", 0, 0, 1, 1, 0, 8'h02, 0, 0);
    step("nosel_rd", 0, 1, 0, 1, 1, 8'h00, 0, 0);

    for (int n = 0; n < 600; n++) begin
      step("rand", ($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 5) != 0,
           int'($urandom % 32), ($urandom % 2) != 0, 8'($urandom),
           ($urandom % 8) == 0, ($urandom % 10) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/maria_reg_bank.md
# maria_reg_bank

Parametrised MARIA register bank that replaces the fixed 7800 register decode with a configurable palette count and a single-clock, strobe-qualified bus interface. It sits between the chip-select decoder and the MARIA display-list engine. It holds background and palette colours, CTRL, CHARBASE and the display-list pointer, and adds two behaviours the fixed decode lacks:

- **DPP double-buffering:** the display-list pointer is committed only at frame start.
- **WSYNC CPU-ready handshake:** the CPU is held until end of line.

## Interface
Parameters:
- NUM_PAL, 8: palette count; power of two, ≥8; register window is 4*NUM_PAL bytes.
- AW, $clog2(4*NUM_PAL): address width (derived; do not override).
- OPEN_BUS, 8'hBE: read value for write-only slots.
- ZP_RESET, 16'h1820: reset value of the DPP shadow and of the active DPP.

Ports:
- sysclock  in  1  system clock; all state on its rising edge.
- reset_b  in  1  synchronous, active-low reset.
- bus_stb  in  1  one-cycle pulse per CPU bus cycle; qualifies sel/addr/we_b/wdata.
- sel  in  1  MARIA window selected by the external decoder.
- addr  in  AW  byte offset within the window.
- we_b  in  1  0 = write, 1 = read.
- wdata  in  8  write data.
- rdata  out  8  registered read data.
- rvalid  out  1  one-cycle pulse when rdata is valid.
- status  in  8  MSTAT value (vblank etc.), sampled on read.
- hblank_pulse  in  1  one-cycle end-of-line pulse.
- frame_start  in  1  one-cycle pulse at the start of a frame.
- cpu_ready  out  1  CPU RDY; low while WSYNC is pending.
- color_map  out  (3*NUM_PAL+1)*8  flattened; byte 0 = background, byte 3p+c+1 = palette p colour c.
- ctrl  out  8  CTRL register.
- char_base  out  8  CHARBASE register.
- zp  out  16  active (committed) DPP.
- zp_valid  out  1  high once any DPP commit has occurred.

## Operation
- Access occurs only when bus_stb & sel; otherwise no state change and rvalid=0.
- Decode uses slot = addr, group g = addr[AW-1:2], lane l = addr[1:0].
- Lanes 1–3: colour register 3g+l, read/write, for every g < NUM_PAL.
- Lane 0, g=0: BKGRND (color_map byte 0), read/write.
- Lane 0, g=1: WSYNC, write-only.
- Lane 0, g=2: MSTAT, read-only; writes ignored.
- Lane 0, g=3: DPPH, write-only.
- Lane 0, g=4: DPPL, write-only.
- Lane 0, g=5: CHARBASE, write-only.
- Lane 0, g=6: unused; reads 0, writes ignored.
- Lane 0, g=7: CTRL, write-only.
- Lane 0, g≥8: reserved; reads 0, writes ignored.
- Write-only slots read OPEN_BUS.
- **DPP:** DPPH/DPPL writes go to a 16-bit shadow and set pend_h/pend_l respectively.
  - On frame_start with pend_h & pend_l: zp <= shadow, zp_valid <= 1, pends clear.
  - On frame_start with only one pend set: no commit; pends retained.
  - A DPP write coinciding with frame_start: the commit decision and value use the pre-write shadow and pends. The write then updates the shadow and sets its pend after the clear.
- **WSYNC FSM, states RUN and HOLD:**
  - RUN→HOLD on a WSYNC write.
  - HOLD→RUN on hblank_pulse.
  - WSYNC write in the same cycle as hblank_pulse: next state is HOLD (write wins), regardless of current state.
  - WSYNC write while already in HOLD: stays HOLD.
  - cpu_ready = (state==RUN), registered.
- CTRL, CHARBASE and colour writes take effect immediately. No double-buffering.

## Timing
- Reset values (reset_b=0 at an edge):
  - color_map all 0, ctrl 8'h40, char_base 0.
  - shadow and zp = ZP_RESET, zp_valid 0, pends 0.
  - FSM RUN, cpu_ready 1, rdata 0, rvalid 0.
- Reset asserted mid-HOLD releases cpu_ready on the next edge.
- Write latency: register outputs update on the edge sampling the strobe, visible next cycle.
- Read latency: rdata/rvalid valid one cycle after the strobe cycle. rvalid is high exactly one cycle. rdata holds its value until the next read.
- MSTAT returns status as sampled on the strobe edge.
- cpu_ready falls the cycle after the WSYNC strobe and rises the cycle after hblank_pulse.
- zp changes the cycle after frame_start only.

## Test plan
- Reset, then read all 4*NUM_PAL slots (NUM_PAL=8 and 16) → colours 0, MSTAT = status, write-only slots 8'hBE, g=6 and g≥8 slots 0; ctrl=8'h40, zp=16'h1820, zp_valid=0.
- Write 8'h3A to offset 0x15 (g=5, l=1 → colour 16), read it back → rdata=8'h3A one cycle after the strobe; color_map byte 16=8'h3A; NUM_PAL=16 offset 0x3F → colour 48.
- DPPH=8'h40 only, frame_start → zp unchanged; then DPPL=8'h80, frame_start → zp=16'h4080, zp_valid=1; DPPL write coinciding with frame_start → that byte is deferred to the following frame.
- WSYNC write → cpu_ready 0 from next cycle; hblank_pulse 10 cycles later → cpu_ready 1 the following cycle; WSYNC write coincident with hblank_pulse → cpu_ready stays 0 until the next hblank.
- Assert reset_b during HOLD with a pending DPPH → cpu_ready=1, pends cleared, zp=16'h1820.
- Strobes with sel=0 or bus_stb=0 carrying writes → no register change, rvalid stays 0.
